half_adder: RTL and testbench
=============================

HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 The module SHALL have parameter DATA_W, default 9: operand width in bits, legal range 1..32.
REQ-002 The module SHALL have parameter LATENCY, default 1: input-to-output delay in clk cycles, legal range 1..4.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port data_in0, input, DATA_W bits: unsigned operand A.
REQ-006 The module SHALL have port data_in1, input, DATA_W bits: unsigned operand B.
REQ-007 The module SHALL have port in_valid, input, 1 bit: high marks operands as valid in the current cycle.
REQ-008 The module SHALL have port data_out, output, DATA_W+1 bits: registered sum.
REQ-009 The module SHALL have port out_valid, output, 1 bit: high marks data_out as a new valid result.

Function
REQ-010 Sum SHALL be data_in0 + data_in1, zero-extended to DATA_W+1 bits; carry goes to the MSB; no truncation, no saturation.
REQ-011 A rising clk edge with in_valid=1 SHALL produce that pair's sum on data_out, with out_valid=1, exactly LATENCY rising edges later (LATENCY=1: visible after the sampling edge itself).
REQ-012 Implementation SHALL be a LATENCY-stage register pipeline; each stage carries a valid bit and a DATA_W+1-bit sum.
REQ-013 The adder SHALL be in the first stage; later stages pass values through.
REQ-014 A stage SHALL load its data only when its incoming valid is 1; otherwise its data holds and its valid register loads 0.
REQ-015 When no valid result arrives, data_out SHALL hold the last valid sum and out_valid SHALL be 0.
REQ-016 No back-pressure: one result per cycle; back-to-back in_valid cycles SHALL give back-to-back out_valid cycles in the same order.
REQ-017 Operands SHALL be sampled only at rising clk edges; input changes between edges SHALL have no effect.
REQ-018 out_valid SHALL be a pure delayed copy of in_valid (LATENCY cycles), independent of operand values.
REQ-019 Boundary: all-ones operands SHALL give 2^(DATA_W+1)-2 (1022 for DATA_W=9); zero plus zero with in_valid=1 SHALL give 0 with out_valid=1.
REQ-020 The design SHALL be purely synchronous apart from rst_n: no latches, no combinational path from input to output.

Reset
REQ-021 While rst_n=0, all pipeline data registers, data_out and out_valid SHALL be 0, asynchronously, with no need for a clock edge.
REQ-022 Reset asserted mid-stream SHALL discard all in-flight results; none SHALL appear after release.
REQ-023 The first rising edge after rst_n rises SHALL sample inputs normally.

Verification
REQ-024 The bench SHALL cover reset: rst_n=0 for 11 ns with a 10 ns clk -> data_out=0 and out_valid=0 throughout and right after release.
REQ-025 The bench SHALL cover back-to-back valid inputs: in_valid=1 with (10,61) then (50,11) on consecutive edges -> data_out=71 then 61, out_valid=1 for both cycles (LATENCY=1).
REQ-026 The bench SHALL cover invalid inputs: in_valid=0 with (26,30) then (3,12) -> out_valid=0 and data_out holds 61.
REQ-027 The bench SHALL cover the maximum case: in_valid=1 with (511,511) -> data_out=1022 with MSB=1 and out_valid=1.
REQ-028 The bench SHALL cover reset mid-operation: rst_n pulsed low between edges while a result is in flight -> outputs go to 0 at once and no out_valid follows.
REQ-029 The bench SHALL cover LATENCY=3 with a stream of 5 valid pairs with gaps -> each sum appears 3 edges later, order kept, gaps kept.

Source files
------------

// File: rtl/half_adder.sv
// rtl/half_adder.sv - pipelined unsigned adder with valid tracking and zero-extended carry
module half_adder #(
  parameter int DATA_W  = 9,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              in_valid,
  output logic [DATA_W:0]   data_out,
  output logic              out_valid
);

  // Per-stage data and valid; the last stage drives the outputs directly.
  logic [DATA_W:0] stage_data  [LATENCY];
  logic            stage_valid [LATENCY];

  // First stage: sum the operands, keeping the carry in the extra MSB; hold the
  // previous sum when nothing valid is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_data[0]  <= '0;
      stage_valid[0] <= 1'b0;
    end else begin
      stage_valid[0] <= in_valid;
      if (in_valid) begin
        stage_data[0] <= {1'b0, data_in0} + {1'b0, data_in1};
      end
    end
  end

  // Later stages forward the sum only alongside a valid bit, otherwise hold.
  for (genvar g = 1; g < LATENCY; g++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_data[g]  <= '0;
        stage_valid[g] <= 1'b0;
      end else begin
        stage_valid[g] <= stage_valid[g-1];
        if (stage_valid[g-1]) begin
          stage_data[g] <= stage_data[g-1];
        end
      end
    end
  end

  assign data_out  = stage_data[LATENCY-1];
  assign out_valid = stage_valid[LATENCY-1];

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - self-checking bench for half_adder at LATENCY 1 and 3
module tb_half_adder;

  localparam int DW = 9;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in0;
  logic [DW-1:0] data_in1;
  logic          in_valid;
  logic [DW:0]   d1_out;
  logic          d1_valid;
  logic [DW:0]   d3_out;
  logic          d3_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: every sampled edge since the last reset, as (valid, sum).
  bit hist_v [1024];
  int hist_s [1024];
  int n_edges;
  int last1;
  int last3;

  half_adder #(.DATA_W(DW), .LATENCY(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .in_valid (in_valid),
    .data_out (d1_out),
    .out_valid(d1_valid)
  );

  half_adder #(.DATA_W(DW), .LATENCY(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .in_valid (in_valid),
    .data_out (d3_out),
    .out_valid(d3_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected output of a LATENCY-L pipeline right now, from the edge history.
  task automatic expect_out(input int lat, input int last, output int exp_d, output int exp_v);
    int idx;
    idx = n_edges - lat;
    if (idx >= 0 && hist_v[idx]) begin
      exp_d = hist_s[idx];
      exp_v = 1;
    end else begin
      exp_d = last;
      exp_v = 0;
    end
  endtask

  task automatic check_all(input string tag);
    int e1d, e1v, e3d, e3v;
    expect_out(1, last1, e1d, e1v);
    expect_out(3, last3, e3d, e3v);
    chk({tag, "_l1_data"},  32'(d1_out),   32'(e1d));
    chk({tag, "_l1_valid"}, 32'(d1_valid), 32'(e1v));
    chk({tag, "_l3_data"},  32'(d3_out),   32'(e3d));
    chk({tag, "_l3_valid"}, 32'(d3_valid), 32'(e3v));
  endtask

  task automatic reset_model();
    n_edges = 0;
    last1   = 0;
    last3   = 0;
  endtask

  // One clock: drive operands, let an edge sample them, check just after the
  // edge, then scribble the inputs and confirm outputs do not move.
  task automatic step(input string tag, input bit v, input int a, input int b);
    int e1d, e1v, e3d, e3v;
    in_valid = v;
    data_in0 = DW'(a);
    data_in1 = DW'(b);
    @(posedge clk);
    hist_v[n_edges] = v;
    hist_s[n_edges] = a + b;
    n_edges++;
    #1;
    check_all(tag);
    expect_out(1, last1, e1d, e1v);
    expect_out(3, last3, e3d, e3v);
    if (e1v != 0) last1 = e1d;
    if (e3v != 0) last3 = e3d;
    in_valid = $urandom_range(0, 1);
    data_in0 = DW'($urandom);
    data_in1 = DW'($urandom);
    #1;
    check_all({tag, "_hold"});
    #1;
  endtask

  initial begin
    reset_model();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_in0 = 9'd300;
    data_in1 = 9'd200;
    #1;
    check_all("rst_t1");
    #5;
    check_all("rst_t6");
    in_valid = 1'b0;
    #5;
    rst_n = 1'b1;
    #1;
    check_all("rst_release");

    step("b2b_a", 1'b1, 10, 61);
    chk("b2b_a_sum", 32'(d1_out), 32'd71);
    step("b2b_b", 1'b1, 50, 11);
    chk("b2b_b_sum", 32'(d1_out), 32'd61);
    step("inv_a", 1'b0, 26, 30);
    step("inv_b", 1'b0, 3, 12);
    chk("inv_hold", 32'(d1_out), 32'd61);
    step("max", 1'b1, 511, 511);
    chk("max_sum", 32'(d1_out), 32'd1022);
    chk("max_msb", 32'(d1_out[DW]), 32'd1);
    step("zero", 1'b1, 0, 0);
    chk("zero_sum", 32'(d1_out), 32'd0);
    chk("zero_valid", 32'(d1_valid), 32'd1);

    // Put a result in flight in the 3-stage pipe, then reset between edges.
    step("inflight", 1'b1, 100, 200);
    rst_n = 1'b0;
    #1;
    reset_model();
    check_all("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("post_rst", 1'b0, 7, 9);

    // Five valid pairs with gaps through both pipelines.
    begin
      bit pat [9] = '{1, 0, 1, 1, 0, 0, 1, 0, 1};
      for (int i = 0; i < 9; i++)
        step("gap_stream", pat[i], int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
    end
    for (int i = 0; i < 4; i++) step("flush", 1'b0, 0, 0);

    for (int i = 0; i < 60; i++)
      step("rand", bit'($urandom_range(0, 1)), int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
